// File: rtl/alu_exec_ctrl.sv
// Execute-stage sequencer for the NZCV ALU: holds the register file and
// architectural flags, issues one instruction at a time to the external ALU,
// evaluates the condition field and commits result/flags after one EXEC cycle.
module alu_exec_ctrl #(
    parameter int N     = 32,
    parameter int IMM_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [3:0]       instr_opcode,
    input  logic [3:0]       instr_cond,
    input  logic             instr_s,
    input  logic [3:0]       instr_rd,
    input  logic [3:0]       instr_rn,
    input  logic [3:0]       instr_rm,
    input  logic             instr_imm_en,
    input  logic [IMM_W-1:0] instr_imm,
    input  logic             host_wr_en,
    input  logic [3:0]       host_wr_addr,
    input  logic [N-1:0]     host_wr_data,
    input  logic [3:0]       dbg_addr,
    output logic [N-1:0]     dbg_data,
    output logic [3:0]       flags_nzcv,
    output logic             done,
    output logic             cond_pass,
    output logic [3:0]       alu_opcode,
    output logic [N-1:0]     alu_op1,
    output logic [N-1:0]     alu_op2,
    output logic [3:0]       alu_flags_in,
    input  logic [N-1:0]     alu_result,
    input  logic [3:0]       alu_flags_out
);

    typedef enum logic {
        IDLE = 1'b0,
        EXEC = 1'b1
    } state_t;

    state_t             state, state_nx;
    logic [N-1:0]       regs [16];
    logic [3:0]         flags_q;
    logic [3:0]         opcode_q, cond_q, rd_q, rn_q, rm_q;
    logic               s_q, imm_en_q;
    logic [IMM_W-1:0]   imm_q;

    logic               accept, pass, is_cmp, wr_reg, wr_flags, host_wr;
    logic               fn, fz, fc, fv;
    logic [3:0]         new_flags;
    logic               alu_z_unused;

    // ALU Z output is sticky and therefore never consumed; Z is recomputed here
    assign alu_z_unused = alu_flags_out[2];

    assign dbg_data     = regs[dbg_addr];
    assign flags_nzcv   = flags_q;
    assign alu_flags_in = flags_q;
    assign alu_opcode   = opcode_q;
    assign alu_op1      = regs[rn_q];
    assign alu_op2      = imm_en_q ? {{(N-IMM_W){1'b0}}, imm_q} : regs[rm_q];
    assign new_flags    = {alu_result[N-1], (alu_result == '0), alu_flags_out[1], alu_flags_out[0]};
    assign {fn, fz, fc, fv} = flags_q;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next state, handshake and commit decisions
    always_comb begin
        state_nx    = state;
        instr_ready = 1'b0;
        accept      = 1'b0;
        host_wr     = 1'b0;
        wr_reg      = 1'b0;
        wr_flags    = 1'b0;
        pass        = 1'b0;
        is_cmp      = (opcode_q == 4'd11) || (opcode_q == 4'd12) || (opcode_q == 4'd13);
        case (cond_q)
            4'd0:    pass = fz;
            4'd1:    pass = ~fz;
            4'd2:    pass = fc;
            4'd3:    pass = ~fc;
            4'd4:    pass = fn;
            4'd5:    pass = ~fn;
            4'd6:    pass = fv;
            4'd7:    pass = ~fv;
            4'd8:    pass = fc & ~fz;
            4'd9:    pass = ~fc | fz;
            4'd10:   pass = (fn == fv);
            4'd11:   pass = (fn != fv);
            4'd12:   pass = ~fz & (fn == fv);
            4'd13:   pass = fz | (fn != fv);
            4'd14:   pass = 1'b1;
            default: pass = 1'b0;
        endcase
        case (state)
            IDLE: begin
                instr_ready = ~host_wr_en;
                host_wr     = host_wr_en;
                accept      = instr_valid & ~host_wr_en;
                if (accept) state_nx = EXEC;
            end
            EXEC: begin
                wr_reg   = pass & ~is_cmp;
                wr_flags = pass & (s_q | is_cmp);
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Datapath: register file, flags, latched instruction, retire pulse
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 16; i++) regs[i] <= '0;
            flags_q   <= '0;
            done      <= 1'b0;
            cond_pass <= 1'b0;
            opcode_q  <= '0;
            cond_q    <= '0;
            rd_q      <= '0;
            rn_q      <= '0;
            rm_q      <= '0;
            s_q       <= 1'b0;
            imm_en_q  <= 1'b0;
            imm_q     <= '0;
        end else begin
            done      <= (state == EXEC);
            cond_pass <= (state == EXEC) & pass;
            if (host_wr) regs[host_wr_addr] <= host_wr_data;
            if (wr_reg)  regs[rd_q] <= alu_result;
            if (wr_flags) flags_q <= new_flags;
            if (accept) begin
                opcode_q <= instr_opcode;
                cond_q   <= instr_cond;
                rd_q     <= instr_rd;
                rn_q     <= instr_rn;
                rm_q     <= instr_rm;
                s_q      <= instr_s;
                imm_en_q <= instr_imm_en;
                imm_q    <= instr_imm;
            end
        end
    end

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Directed bench for alu_exec_ctrl with a behavioural NZCV ALU attached.
// ALU opcode map used here: 0 AND, 1 EOR, 2 SUB, 4 ADD, 11 TEQ, 12 CMP,
// 13 CMN, 14 MOV, 15 MVN. Its Z output is deliberately sticky.
module tb_alu_exec_ctrl;

    localparam int N = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          instr_valid;
    logic          instr_ready;
    logic [3:0]    instr_opcode, instr_cond, instr_rd, instr_rn, instr_rm;
    logic          instr_s, instr_imm_en;
    logic [7:0]    instr_imm;
    logic          host_wr_en;
    logic [3:0]    host_wr_addr;
    logic [N-1:0]  host_wr_data;
    logic [3:0]    dbg_addr;
    logic [N-1:0]  dbg_data;
    logic [3:0]    flags_nzcv;
    logic          done, cond_pass;
    logic [3:0]    alu_opcode, alu_flags_in, alu_flags_out;
    logic [N-1:0]  alu_op1, alu_op2, alu_result;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_exec_ctrl #(.N(N), .IMM_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_opcode(instr_opcode), .instr_cond(instr_cond), .instr_s(instr_s),
        .instr_rd(instr_rd), .instr_rn(instr_rn), .instr_rm(instr_rm),
        .instr_imm_en(instr_imm_en), .instr_imm(instr_imm),
        .host_wr_en(host_wr_en), .host_wr_addr(host_wr_addr), .host_wr_data(host_wr_data),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data), .flags_nzcv(flags_nzcv),
        .done(done), .cond_pass(cond_pass),
        .alu_opcode(alu_opcode), .alu_op1(alu_op1), .alu_op2(alu_op2),
        .alu_flags_in(alu_flags_in), .alu_result(alu_result), .alu_flags_out(alu_flags_out)
    );

    // Behavioural ALU: arithmetic sets C/V, logical passes C/V through, Z sticky
    always_comb begin
        logic [N:0] sum;
        logic c, v;
        sum = '0;
        c = alu_flags_in[1];
        v = alu_flags_in[0];
        alu_result = '0;
        case (alu_opcode)
            4'd2, 4'd12: begin
                alu_result = alu_op1 - alu_op2;
                c = (alu_op1 >= alu_op2);
                v = (alu_op1[N-1] != alu_op2[N-1]) && (alu_result[N-1] != alu_op1[N-1]);
            end
            4'd4, 4'd13: begin
                sum = {1'b0, alu_op1} + {1'b0, alu_op2};
                alu_result = sum[N-1:0];
                c = sum[N];
                v = (alu_op1[N-1] == alu_op2[N-1]) && (alu_result[N-1] != alu_op1[N-1]);
            end
            4'd1, 4'd11: alu_result = alu_op1 ^ alu_op2;
            4'd14:       alu_result = alu_op2;
            4'd15:       alu_result = ~alu_op2;
            default:     alu_result = alu_op1 & alu_op2;
        endcase
        alu_flags_out = {alu_result[N-1], alu_flags_in[2] | (alu_result == '0), c, v};
    end

    typedef struct {
        string        name;
        logic [3:0]   opc, cond;
        logic         s;
        logic [3:0]   rd, rn, rm;
        logic         imm_en;
        logic [7:0]   imm;
        logic [3:0]   chk;
        logic         pass;
        logic [N-1:0] val;
        logic [3:0]   flags;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(string name, logic [3:0] opc, logic [3:0] cond, logic s,
                                logic [3:0] rd, logic [3:0] rn, logic [3:0] rm, logic imm_en,
                                logic [7:0] imm, logic [3:0] chk, logic pass,
                                logic [N-1:0] val, logic [3:0] flags);
        vec_t t;
        t.name = name; t.opc = opc; t.cond = cond; t.s = s; t.rd = rd; t.rn = rn; t.rm = rm;
        t.imm_en = imm_en; t.imm = imm; t.chk = chk; t.pass = pass; t.val = val; t.flags = flags;
        return t;
    endfunction

    task automatic check(string name, logic [N-1:0] act, logic [N-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic host_write(logic [3:0] a, logic [N-1:0] d);
        @(negedge clk);
        host_wr_en = 1'b1; host_wr_addr = a; host_wr_data = d;
        @(posedge clk); #1;
        host_wr_en = 1'b0;
    endtask

    task automatic drive_instr(vec_t t);
        instr_opcode = t.opc; instr_cond = t.cond; instr_s = t.s; instr_rd = t.rd;
        instr_rn = t.rn; instr_rm = t.rm; instr_imm_en = t.imm_en; instr_imm = t.imm;
        instr_valid = 1'b1;
    endtask

    task automatic reg_check(string name, logic [3:0] a, logic [N-1:0] exp);
        dbg_addr = a; #1;
        check(name, dbg_data, exp);
    endtask

    // Issue one instruction and check retirement exactly one cycle after accept
    task automatic run_vec(vec_t t);
        @(negedge clk);
        drive_instr(t);
        dbg_addr = t.chk;
        check({t.name, ".ready"}, {31'b0, instr_ready}, 1);
        @(posedge clk); #1;
        instr_valid = 1'b0;
        @(negedge clk);
        check({t.name, ".exec_ready"}, {31'b0, instr_ready}, 0);
        check({t.name, ".exec_done"}, {31'b0, done}, 0);
        @(negedge clk);
        check({t.name, ".done"}, {31'b0, done}, 1);
        check({t.name, ".pass"}, {31'b0, cond_pass}, {31'b0, t.pass});
        check({t.name, ".reg"}, dbg_data, t.val);
        check({t.name, ".flags"}, {28'b0, flags_nzcv}, {28'b0, t.flags});
        @(negedge clk);
        check({t.name, ".done_pulse"}, {31'b0, done}, 0);
    endtask

    initial begin
        vec_t t;
        rst_n = 1'b0; instr_valid = 1'b0; host_wr_en = 1'b0; host_wr_addr = '0;
        host_wr_data = '0; dbg_addr = '0;
        t = mk("init", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive_instr(t);
        instr_valid = 1'b0;

        //        name     opc cond s  rd  rn  rm  ie imm   chk pass value          flags
        vecs.push_back(mk("sub",   2, 14, 1, 3,  1,  2, 0, 0,    3,  1, 32'h2,        4'b0010));
        vecs.push_back(mk("addov", 4, 14, 1, 5,  4,  0, 1, 1,    5,  1, 32'h80000000, 4'b1001));
        vecs.push_back(mk("cmp",   12,14, 0, 1,  1,  1, 0, 0,    1,  1, 32'h5,        4'b0110));
        vecs.push_back(mk("movne", 14, 1, 0, 6,  0,  0, 1, 0,    6,  0, 32'h55,       4'b0110));
        vecs.push_back(mk("moveq", 14, 0, 0, 6,  0,  0, 1, 0,    6,  1, 32'h0,        4'b0110));
        vecs.push_back(mk("zclr",  4, 14, 1, 7,  1,  2, 0, 0,    7,  1, 32'h8,        4'b0000));
        vecs.push_back(mk("subneg",2, 14, 1, 10, 2,  1, 0, 0,    10, 1, 32'hFFFFFFFE, 4'b1000));
        vecs.push_back(mk("movgt", 14,12, 0, 10, 0,  0, 1, 7,    10, 0, 32'hFFFFFFFE, 4'b1000));
        vecs.push_back(mk("movlt", 14,11, 0, 10, 0,  0, 1, 7,    10, 1, 32'h7,        4'b1000));
        vecs.push_back(mk("teq",   11,14, 0, 10, 1,  1, 0, 0,    10, 1, 32'h7,        4'b0100));
        vecs.push_back(mk("movhi", 14, 8, 0, 11, 0,  0, 1, 9,    11, 0, 32'h0,        4'b0100));
        vecs.push_back(mk("movls", 14, 9, 0, 11, 0,  0, 1, 9,    11, 1, 32'h9,        4'b0100));
        vecs.push_back(mk("cmn",   13,14, 0, 11, 4,  4, 0, 0,    11, 1, 32'h9,        4'b1001));
        vecs.push_back(mk("movge", 14,10, 1, 11, 0,  0, 1, 8'hFF,11, 1, 32'hFF,       4'b0001));
        vecs.push_back(mk("nv",    4, 15, 0, 2,  2,  0, 1, 2,    2,  0, 32'h3,        4'b0001));
        vecs.push_back(mk("addvs", 4,  6, 0, 2,  2,  0, 1, 2,    2,  1, 32'h5,        4'b0001));

        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst.ready", {31'b0, instr_ready}, 1);
        check("rst.done", {31'b0, done}, 0);
        check("rst.flags", {28'b0, flags_nzcv}, 0);
        reg_check("rst.r15", 15, 0);

        host_write(1, 5);
        host_write(2, 3);
        host_write(4, 32'h7FFFFFFF);
        host_write(6, 32'h55);

        foreach (vecs[i]) run_vec(vecs[i]);

        // Host write and instruction offered together: only the host write lands
        @(negedge clk);
        t = mk("prio", 4, 14, 1, 13, 1, 2, 0, 0, 0, 0, 0, 0);
        drive_instr(t);
        host_wr_en = 1'b1; host_wr_addr = 12; host_wr_data = 32'hAB;
        #1 check("prio.ready", {31'b0, instr_ready}, 0);
        @(posedge clk); #1;
        instr_valid = 1'b0; host_wr_en = 1'b0;
        @(negedge clk);
        check("prio.idle", {31'b0, instr_ready}, 1);
        check("prio.nodone", {31'b0, done}, 0);
        reg_check("prio.r12", 12, 32'hAB);
        reg_check("prio.r13", 13, 0);

        // Host write during EXEC is ignored
        @(negedge clk);
        t = mk("exhost", 14, 14, 0, 14, 0, 0, 1, 3, 0, 0, 0, 0);
        drive_instr(t);
        @(posedge clk); #1;
        instr_valid = 1'b0;
        host_wr_en = 1'b1; host_wr_addr = 14; host_wr_data = 32'hDEAD;
        @(posedge clk); #1;
        host_wr_en = 1'b0;
        @(negedge clk);
        check("exhost.done", {31'b0, done}, 1);
        reg_check("exhost.r14", 14, 3);

        // Reset during EXEC aborts the instruction
        @(negedge clk);
        t = mk("abort", 4, 14, 1, 8, 1, 2, 0, 0, 0, 0, 0, 0);
        drive_instr(t);
        @(posedge clk); #1;
        instr_valid = 1'b0; rst_n = 1'b0;
        @(posedge clk); #1;
        check("abort.nodone", {31'b0, done}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("abort.done2", {31'b0, done}, 0);
        check("abort.ready", {31'b0, instr_ready}, 1);
        check("abort.flags", {28'b0, flags_nzcv}, 0);
        reg_check("abort.r8", 8, 0);
        reg_check("abort.r1", 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
